// File: rtl/change_dispenser.sv
// Change dispenser: accumulates refund amounts from the vending FSM and pays them
// out greedily as 10/5/1 coins over a valid/ready hopper handshake, tracking stock.
module change_dispenser #(
  parameter int INIT_10 = 20,
  parameter int INIT_5  = 20,
  parameter int INIT_1  = 20,
  parameter int STOCK_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        change,
  input  logic               hopper_ready,
  input  logic               refill,
  output logic               coin_valid,
  output logic [31:0]        coin_value,
  output logic [31:0]        remaining,
  output logic               busy,
  output logic               shortfall,
  output logic [STOCK_W-1:0] stock10,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock1
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PRESENT = 2'd2,
    SHORT   = 2'd3
  } state_t;

  localparam logic [STOCK_W-1:0] INIT_10_S = STOCK_W'(INIT_10);
  localparam logic [STOCK_W-1:0] INIT_5_S  = STOCK_W'(INIT_5);
  localparam logic [STOCK_W-1:0] INIT_1_S  = STOCK_W'(INIT_1);
  localparam logic [STOCK_W-1:0] STOCK_ONE = STOCK_W'(1);
  localparam logic [STOCK_W-1:0] STOCK_ZERO = STOCK_W'(0);

  state_t             state_q, state_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [31:0]        prev_change_q, prev_change_d;
  logic [31:0]        coin_value_q, coin_value_d;
  logic               coin_valid_q, coin_valid_d;
  logic               busy_q, busy_d;
  logic               shortfall_q, shortfall_d;
  logic [STOCK_W-1:0] stock10_q, stock10_d;
  logic [STOCK_W-1:0] stock5_q, stock5_d;
  logic [STOCK_W-1:0] stock1_q, stock1_d;
  logic               load_s;
  logic               xfer_s;

  // Load/transfer events and the owed-amount update.
  always_comb begin
    load_s        = (change != 32'd0) && (change != prev_change_q);
    xfer_s        = coin_valid_q && hopper_ready;
    prev_change_d = change;
    remaining_d   = remaining_q - (xfer_s ? coin_value_q : 32'd0)
                                + (load_s ? change : 32'd0);
  end

  // Stock bookkeeping; a refill overrides a coincident decrement.
  always_comb begin
    stock10_d = stock10_q;
    stock5_d  = stock5_q;
    stock1_d  = stock1_q;
    if (refill) begin
      stock10_d = INIT_10_S;
      stock5_d  = INIT_5_S;
      stock1_d  = INIT_1_S;
    end else if (xfer_s) begin
      case (coin_value_q)
        32'd10:  stock10_d = stock10_q - STOCK_ONE;
        32'd5:   stock5_d  = stock5_q - STOCK_ONE;
        32'd1:   stock1_d  = stock1_q - STOCK_ONE;
        default: stock1_d  = stock1_q;
      endcase
    end else begin
      stock1_d = stock1_q;
    end
  end

  // Dispense FSM: next state, coin selection and registered output flags.
  always_comb begin
    state_d      = state_q;
    coin_value_d = coin_value_q;
    case (state_q)
      IDLE: begin
        coin_value_d = 32'd0;
        if (remaining_q != 32'd0) begin
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      SELECT: begin
        // Greedy pick; an empty denomination is never chosen.
        if (remaining_q == 32'd0) begin
          coin_value_d = 32'd0;
          state_d      = IDLE;
        end else if ((remaining_q >= 32'd10) && (stock10_q != STOCK_ZERO)) begin
          coin_value_d = 32'd10;
          state_d      = PRESENT;
        end else if ((remaining_q >= 32'd5) && (stock5_q != STOCK_ZERO)) begin
          coin_value_d = 32'd5;
          state_d      = PRESENT;
        end else if (stock1_q != STOCK_ZERO) begin
          coin_value_d = 32'd1;
          state_d      = PRESENT;
        end else begin
          coin_value_d = 32'd0;
          state_d      = SHORT;
        end
      end
      PRESENT: begin
        if (xfer_s) begin
          coin_value_d = 32'd0;
          state_d      = (remaining_d != 32'd0) ? SELECT : IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      SHORT: begin
        coin_value_d = 32'd0;
        if (refill) begin
          state_d = (remaining_d != 32'd0) ? SELECT : IDLE;
        end else begin
          state_d = SHORT;
        end
      end
      default: begin
        coin_value_d = 32'd0;
        state_d      = IDLE;
      end
    endcase
    coin_valid_d = (state_d == PRESENT);
    busy_d       = (state_d != IDLE);
    shortfall_d  = (state_d == SHORT);
  end

  // State and datapath registers; reset abandons any dispense in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= 32'd0;
      prev_change_q <= 32'd0;
      coin_value_q  <= 32'd0;
      coin_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      shortfall_q   <= 1'b0;
      stock10_q     <= INIT_10_S;
      stock5_q      <= INIT_5_S;
      stock1_q      <= INIT_1_S;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      prev_change_q <= prev_change_d;
      coin_value_q  <= coin_value_d;
      coin_valid_q  <= coin_valid_d;
      busy_q        <= busy_d;
      shortfall_q   <= shortfall_d;
      stock10_q     <= stock10_d;
      stock5_q      <= stock5_d;
      stock1_q      <= stock1_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_value = coin_value_q;
  assign remaining  = remaining_q;
  assign busy       = busy_q;
  assign shortfall  = shortfall_q;
  assign stock10    = stock10_q;
  assign stock5     = stock5_q;
  assign stock1     = stock1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser: default-stock instance (a)
// plus a low 1-coin stock instance (b) for the shortfall/refill path.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] change_a = 32'd0, change_b = 32'd0;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic        refill_a = 1'b0, refill_b = 1'b0;
  logic        coin_valid_a, coin_valid_b, busy_a, busy_b, shortfall_a, shortfall_b;
  logic [31:0] coin_value_a, coin_value_b, remaining_a, remaining_b;
  logic [7:0]  stock10_a, stock5_a, stock1_a, stock10_b, stock5_b, stock1_b;

  int checks = 0;
  int errors = 0;
  int got_a[$];
  int got_b[$];

  always #5 clk = ~clk;

  change_dispenser dut_a (
    .clk(clk), .reset(reset), .change(change_a), .hopper_ready(ready_a), .refill(refill_a),
    .coin_valid(coin_valid_a), .coin_value(coin_value_a), .remaining(remaining_a),
    .busy(busy_a), .shortfall(shortfall_a),
    .stock10(stock10_a), .stock5(stock5_a), .stock1(stock1_a)
  );

  change_dispenser #(.INIT_1(2)) dut_b (
    .clk(clk), .reset(reset), .change(change_b), .hopper_ready(ready_b), .refill(refill_b),
    .coin_valid(coin_valid_b), .coin_value(coin_value_b), .remaining(remaining_b),
    .busy(busy_b), .shortfall(shortfall_b),
    .stock10(stock10_b), .stock5(stock5_b), .stock1(stock1_b)
  );

  // Advance n cycles, logging every coin accepted by the hopper.
  task automatic run_a(input int n);
    for (int i = 0; i < n; i++) begin
      if (coin_valid_a && ready_a) got_a.push_back(int'(coin_value_a));
      @(negedge clk);
    end
  endtask

  task automatic run_b(input int n);
    for (int i = 0; i < n; i++) begin
      if (coin_valid_b && ready_b) got_b.push_back(int'(coin_value_b));
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({coin_valid_a, busy_a, shortfall_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {coin_valid_a, busy_a, shortfall_a});
    end
    checks++;
    if (coin_value_a !== 32'd0 || remaining_a !== 32'd0) begin
      errors++; $display("FAIL reset_values: got coin=%0d rem=%0d expected 0/0", coin_value_a, remaining_a);
    end
    checks++;
    if ({stock10_a, stock5_a, stock1_a} !== {8'd20, 8'd20, 8'd20}) begin
      errors++; $display("FAIL reset_stock: got %0d/%0d/%0d expected 20/20/20", stock10_a, stock5_a, stock1_a);
    end
    checks++;
    if (stock1_b !== 8'd2) begin
      errors++; $display("FAIL reset_stock_b: got %0d expected 2", stock1_b);
    end
  endtask

  task automatic test_small;
    change_a = 32'd6; ready_a = 1'b1;
    @(negedge clk);
    change_a = 32'd0;
    checks++;
    if (remaining_a !== 32'd6 || busy_a !== 1'b0) begin
      errors++; $display("FAIL small_load: got rem=%0d busy=%b expected 6/0", remaining_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || coin_valid_a !== 1'b0) begin
      errors++; $display("FAIL small_select: got busy=%b valid=%b expected 1/0", busy_a, coin_valid_a);
    end
    @(negedge clk);
    checks++;
    if (coin_valid_a !== 1'b1 || coin_value_a !== 32'd5) begin
      errors++; $display("FAIL small_coin5: got valid=%b value=%0d expected 1/5", coin_valid_a, coin_value_a);
    end
    @(negedge clk);
    checks++;
    if (remaining_a !== 32'd1 || coin_valid_a !== 1'b0 || stock5_a !== 8'd19) begin
      errors++; $display("FAIL small_after5: got rem=%0d valid=%b s5=%0d expected 1/0/19", remaining_a, coin_valid_a, stock5_a);
    end
    @(negedge clk);
    checks++;
    if (coin_valid_a !== 1'b1 || coin_value_a !== 32'd1) begin
      errors++; $display("FAIL small_coin1: got valid=%b value=%0d expected 1/1", coin_valid_a, coin_value_a);
    end
    @(negedge clk);
    checks++;
    if (remaining_a !== 32'd0 || busy_a !== 1'b0 || stock1_a !== 8'd19 || coin_value_a !== 32'd0) begin
      errors++; $display("FAIL small_done: got rem=%0d busy=%b s1=%0d coin=%0d expected 0/0/19/0", remaining_a, busy_a, stock1_a, coin_value_a);
    end
  endtask

  task automatic test_held;
    int exp_coins[4];
    exp_coins = '{10, 10, 5, 1};
    got_a.delete();
    change_a = 32'd26; ready_a = 1'b1;
    run_a(6);
    change_a = 32'd0;
    run_a(14);
    checks++;
    if (got_a.size() !== 4) begin
      errors++; $display("FAIL held_count: got %0d coins expected 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_a[i] !== exp_coins[i]) begin
          errors++; $display("FAIL held_coin%0d: got %0d expected %0d", i, got_a[i], exp_coins[i]);
        end
      end
    end
    checks++;
    if (remaining_a !== 32'd0 || stock10_a !== 8'd18 || stock5_a !== 8'd18 || stock1_a !== 8'd18 || busy_a !== 1'b0) begin
      errors++; $display("FAIL held_final: got rem=%0d s=%0d/%0d/%0d busy=%b expected 0 18/18/18 0", remaining_a, stock10_a, stock5_a, stock1_a, busy_a);
    end
  endtask

  task automatic test_stall;
    bit found = 1'b0;
    change_a = 32'd10; ready_a = 1'b0;
    @(negedge clk);
    change_a = 32'd0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (coin_valid_a) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stall_timeout: got no coin_valid expected coin within 10 cycles");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (coin_valid_a !== 1'b1 || coin_value_a !== 32'd10) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b value=%0d expected 1/10", i, coin_valid_a, coin_value_a);
      end
      @(negedge clk);
    end
    ready_a = 1'b1;
    @(negedge clk);
    checks++;
    if (coin_valid_a !== 1'b0 || remaining_a !== 32'd0 || stock10_a !== 8'd17) begin
      errors++; $display("FAIL stall_xfer: got valid=%b rem=%0d s10=%0d expected 0/0/17", coin_valid_a, remaining_a, stock10_a);
    end
    got_a.delete();
    run_a(4);
    checks++;
    if (got_a.size() !== 0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL stall_single: got extra=%0d busy=%b expected 0/0", got_a.size(), busy_a);
    end
  endtask

  task automatic test_shortfall;
    got_b.delete();
    change_b = 32'd3; ready_b = 1'b1;
    @(negedge clk);
    change_b = 32'd0;
    run_b(8);
    checks++;
    if (got_b.size() !== 2 || (got_b.size() == 2 && (got_b[0] !== 1 || got_b[1] !== 1))) begin
      errors++; $display("FAIL short_coins: got %0d coins expected two 1-coins", got_b.size());
    end
    checks++;
    if (shortfall_b !== 1'b1 || remaining_b !== 32'd1 || stock1_b !== 8'd0 || coin_valid_b !== 1'b0) begin
      errors++; $display("FAIL short_state: got short=%b rem=%0d s1=%0d valid=%b expected 1/1/0/0", shortfall_b, remaining_b, stock1_b, coin_valid_b);
    end
    refill_b = 1'b1;
    @(negedge clk);
    refill_b = 1'b0;
    checks++;
    if (stock1_b !== 8'd2 || shortfall_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++; $display("FAIL short_refill: got s1=%0d short=%b busy=%b expected 2/0/1", stock1_b, shortfall_b, busy_b);
    end
    got_b.delete();
    run_b(6);
    checks++;
    if (got_b.size() !== 1 || (got_b.size() == 1 && got_b[0] !== 1)) begin
      errors++; $display("FAIL short_resume: got %0d coins expected one 1-coin", got_b.size());
    end
    checks++;
    if (remaining_b !== 32'd0 || shortfall_b !== 1'b0 || stock1_b !== 8'd1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL short_done: got rem=%0d short=%b s1=%0d busy=%b expected 0/0/1/0", remaining_b, shortfall_b, stock1_b, busy_b);
    end
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    int valid_seen = 0;
    change_a = 32'd20; ready_a = 1'b0;
    @(negedge clk);
    change_a = 32'd0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (coin_valid_a) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_timeout: got no coin_valid expected coin within 10 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (remaining_a !== 32'd0 || coin_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got rem=%0d valid=%b busy=%b expected 0/0/0", remaining_a, coin_valid_a, busy_a);
    end
    checks++;
    if ({stock10_a, stock5_a, stock1_a} !== {8'd20, 8'd20, 8'd20}) begin
      errors++; $display("FAIL rstmid_stock: got %0d/%0d/%0d expected 20/20/20", stock10_a, stock5_a, stock1_a);
    end
    for (int i = 0; i < 5; i++) begin
      if (coin_valid_a) valid_seen++;
      @(negedge clk);
    end
    checks++;
    if (valid_seen !== 0) begin
      errors++; $display("FAIL rstmid_quiet: got %0d valid cycles expected 0", valid_seen);
    end
  endtask

  task automatic test_back_to_back;
    int exp_coins[3];
    exp_coins = '{10, 1, 1};
    got_a.delete();
    ready_a = 1'b1;
    change_a = 32'd5;
    @(negedge clk);
    change_a = 32'd7;
    @(negedge clk);
    change_a = 32'd0;
    checks++;
    if (remaining_a !== 32'd12) begin
      errors++; $display("FAIL b2b_accum: got rem=%0d expected 12", remaining_a);
    end
    run_a(12);
    checks++;
    if (got_a.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d coins expected 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_a[i] !== exp_coins[i]) begin
          errors++; $display("FAIL b2b_coin%0d: got %0d expected %0d", i, got_a[i], exp_coins[i]);
        end
      end
    end
    checks++;
    if (remaining_a !== 32'd0 || stock10_a !== 8'd19 || stock1_a !== 8'd18 || busy_a !== 1'b0) begin
      errors++; $display("FAIL b2b_final: got rem=%0d s10=%0d s1=%0d busy=%b expected 0/19/18/0", remaining_a, stock10_a, stock1_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_held();
    test_stall();
    test_shortfall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
